trap_unit: RTL and testbench
============================

# trap_unit

Machine-mode trap controller at the receiving end of the writeback stage's exception interface. Consumes the retired-exception and retired-`mret` signals from writeback and sequences trap entry and return: it updates the trap CSRs, flushes the pipeline, and hands a redirect PC to fetch. It also exposes a software CSR access port for the machine trap registers.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `MTVEC_RESET`, 64'h0000_0000_8000_0000: reset value of mtvec.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `exception_in`  in  1  retired instruction raised an exception (writeback `exception_out`).
- `exception_pc_in`  in  XLEN  PC of the faulting instruction.
- `exception_cause_in`  in  4  exception code.
- `mret_in`  in  1  an `mret` retired this cycle.
- `csr_addr`  in  12  CSR address for the software port.
- `csr_we`  in  1  CSR write strobe.
- `csr_wdata`  in  XLEN  CSR write data.
- `csr_rdata`  out  XLEN  combinational read data for `csr_addr`.
- `flush_out`  out  1  squash all in-flight pipeline stages.
- `stall_out`  out  1  hold fetch and decode while a trap is being processed.
- `redirect_valid`  out  1  `redirect_pc` is valid.
- `redirect_pc`  out  XLEN  next fetch PC.
- `redirect_ready`  in  1  fetch accepts the redirect.

## Operation
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE, `exception_in`=1:
  - mepc <= {`exception_pc_in`[XLEN-1:2], 2'b00}.
  - mcause <= zero-extended `exception_cause_in`; bit XLEN-1 = 0.
  - MPIE <= MIE; MIE <= 0.
  - Target <= mtvec. Go to FLUSH.
- IDLE, `mret_in`=1 and no exception:
  - MIE <= MPIE; MPIE <= 1.
  - Target <= mepc. Go to FLUSH.
- If `exception_in` and `mret_in` are both high in the same cycle, the exception wins.
- FLUSH: `flush_out`=1 and `stall_out`=1 for exactly one cycle, then go to REDIRECT.
- REDIRECT: `redirect_valid`=1, `redirect_pc`=captured target, `stall_out`=1. Hold until `redirect_valid && redirect_ready`, then go to IDLE on that edge.
- `exception_in` and `mret_in` are ignored outside IDLE; the flushed pipeline makes them stale.
- CSR map (any other address reads 0 and ignores writes):
  - 0x300 mstatus: only MIE (bit 3) and MPIE (bit 7) are writable; all other bits read 0.
  - 0x305 mtvec: direct mode only; bits [1:0] are forced to 0 on write.
  - 0x340 mscratch: full XLEN read/write.
  - 0x341 mepc: bits [1:0] are forced to 0.
  - 0x342 mcause: full XLEN read/write.
- A software write and a trap or mret update to the same CSR in the same cycle: the trap or mret update wins.
- A write to mtvec or mepc in the same cycle as trap capture does not affect the captured target.

## Timing
- Reset values:
  - State IDLE.
  - `flush_out`, `stall_out`, `redirect_valid` = 0.
  - `redirect_pc` = 0.
  - mtvec = `MTVEC_RESET`; mepc, mcause, mscratch = 0; MIE = MPIE = 0.
- Exception seen at edge N: CSRs updated at edge N; `flush_out` high during cycle N+1; `redirect_valid` high from cycle N+2.
- Minimum trap-to-redirect latency is 2 cycles. Minimum occupancy is 3 cycles when `redirect_ready` is already high.
- `redirect_pc` is stable while `redirect_valid` is high.
- `csr_rdata` is combinational and reflects register state before the current edge's update.
- Reset asserted in any state returns to IDLE at the next edge. No redirect or flush is issued after reset, and partially committed CSR updates are overwritten by reset values.
- Back-to-back traps: a new exception is accepted in the first IDLE cycle after the REDIRECT handshake.

## Structure
- `trap_pkg`:
  - FSM state enum.
  - CSR address constants (`CSR_MSTATUS`, `CSR_MTVEC`, `CSR_MSCRATCH`, `CSR_MEPC`, `CSR_MCAUSE`).
  - mstatus bit positions (`MSTATUS_MIE`=3, `MSTATUS_MPIE`=7).
- One sub-module, `trap_csr_regs`: holds mstatus, mtvec, mscratch, mepc and mcause; implements write masking and read mux; takes trap-update and mret-update strobes with priority over the software write.
- The top level holds the FSM, the target register and the redirect handshake.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-REDIRECT.
  - Next cycle `redirect_valid`=0.
  - mtvec reads 0x8000_0000; other CSRs read 0.
- **Trap entry:** MIE=1, `exception_in`=1 with pc 0x1006 and cause 2, `redirect_ready`=1.
  - mepc=0x1004, mcause=2, MIE=0, MPIE=1.
  - `flush_out` high 1 cycle, then `redirect_pc`=mtvec for 1 cycle.
- **Backpressure:** `redirect_ready`=0 for 5 cycles.
  - `redirect_valid` and `redirect_pc` are held stable.
  - An `exception_in` pulse during the wait is ignored; mepc is unchanged.
- **Return:** mepc=0x2000, MPIE=1, `mret_in`=1.
  - `redirect_pc`=0x2000, MIE=1, MPIE=1.
- **Simultaneous events:** `exception_in` and `mret_in` both high with pc 0x3000 and cause 11.
  - Trap path taken: mcause=11, redirect to mtvec.
- **CSR port:**
  - Write mtvec 0x4003: reads 0x4000.
  - Write mstatus all-ones: reads 0x88.
  - Read 0x7C0: returns 0.
  - mepc written in the same cycle as a trap: mepc holds the trap PC.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM state
// encoding, trap CSR addresses and mstatus bit positions.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

endpackage

// File: rtl/trap_csr_regs.sv
// Machine trap CSR file: mstatus (MIE/MPIE only), mtvec, mscratch, mepc,
// mcause. Software write port with per-register masking, combinational
// read mux, and trap/mret update strobes that override software writes.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   trap_en          capture trap: mepc/mcause/mstatus updated
//   trap_pc          faulting PC (low two bits dropped)
//   trap_cause       4-bit exception code
//   mret_en          return: MIE <= MPIE, MPIE <= 1
//   csr_addr/we/wdata  software write port
//   csr_rdata        combinational read data (pre-edge state)
//   mtvec, mepc      current values used as redirect targets
module trap_csr_regs
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [3:0]      trap_cause,
  input  logic            mret_en,
  input  logic [11:0]     csr_addr,
  input  logic            csr_we,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mcause;

  // Trap PCs are word aligned; the low bits are intentionally discarded.
  logic unused_pc_bits;
  assign unused_pc_bits = ^trap_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      if (csr_we) begin
        unique case (csr_addr)
          CSR_MSTATUS: begin
            mie  <= csr_wdata[MSTATUS_MIE];
            mpie <= csr_wdata[MSTATUS_MPIE];
          end
          CSR_MTVEC:    mtvec    <= {csr_wdata[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: mscratch <= csr_wdata;
          CSR_MEPC:     mepc     <= {csr_wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause   <= csr_wdata;
          default: ;
        endcase
      end
      // Hardware updates come after the software write so that, for the
      // same register, the later non-blocking assignment takes effect.
      if (trap_en) begin
        mepc   <= {trap_pc[XLEN-1:2], 2'b00};
        mcause <= {{(XLEN-4){1'b0}}, trap_cause};
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (mret_en) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = mie;
        csr_rdata[MSTATUS_MPIE] = mpie;
      end
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      default:      csr_rdata = '0;
    endcase
  end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap controller. Accepts retired exceptions and mret from
// writeback, updates trap CSRs, flushes the pipeline for one cycle, then
// presents a redirect PC to fetch until it is accepted.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   exception_in/_pc_in/_cause_in  retired exception from writeback
//   mret_in                     retired mret
//   csr_addr/we/wdata/rdata     software CSR port
//   flush_out, stall_out        pipeline control
//   redirect_valid/pc/ready     redirect handshake with fetch
module trap_unit
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exception_in,
  input  logic [XLEN-1:0] exception_pc_in,
  input  logic [3:0]      exception_cause_in,
  input  logic            mret_in,
  input  logic [11:0]     csr_addr,
  input  logic            csr_we,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            flush_out,
  output logic            stall_out,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  state_t          state;
  state_t          state_next;
  logic            trap_en;
  logic            mret_en;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] target;

  // Events are only honoured in IDLE; exception beats mret.
  assign trap_en = (state == ST_IDLE) && exception_in;
  assign mret_en = (state == ST_IDLE) && mret_in && !exception_in;

  trap_csr_regs #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr (
    .clk        (clk),
    .reset      (reset),
    .trap_en    (trap_en),
    .trap_pc    (exception_pc_in),
    .trap_cause (exception_cause_in),
    .mret_en    (mret_en),
    .csr_addr   (csr_addr),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .mtvec      (mtvec),
    .mepc       (mepc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (trap_en || mret_en) state_next = ST_FLUSH;
      ST_FLUSH:    state_next = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flush_out      = 1'b0;
    stall_out      = 1'b0;
    redirect_valid = 1'b0;
    unique case (state)
      ST_FLUSH: begin
        flush_out = 1'b1;
        stall_out = 1'b1;
      end
      ST_REDIRECT: begin
        stall_out      = 1'b1;
        redirect_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Target is sampled from pre-edge CSR values, so a same-cycle software
  // write to mtvec/mepc cannot leak into the redirect.
  always_ff @(posedge clk) begin
    if (reset)        target <= '0;
    else if (trap_en) target <= mtvec;
    else if (mret_en) target <= mepc;
  end

  assign redirect_pc = target;

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: CSR port vectors from a table, plus
// hand-written sequences for trap entry, backpressure, mret, simultaneous
// events, same-cycle CSR writes and reset during REDIRECT.
module tb_trap_unit;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            exception_in;
  logic [XLEN-1:0] exception_pc_in;
  logic [3:0]      exception_cause_in;
  logic            mret_in;
  logic [11:0]     csr_addr;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            flush_out;
  logic            stall_out;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  trap_unit #(
    .XLEN        (XLEN),
    .MTVEC_RESET (64'h0000_0000_8000_0000)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .exception_in       (exception_in),
    .exception_pc_in    (exception_pc_in),
    .exception_cause_in (exception_cause_in),
    .mret_in            (mret_in),
    .csr_addr           (csr_addr),
    .csr_we             (csr_we),
    .csr_wdata          (csr_wdata),
    .csr_rdata          (csr_rdata),
    .flush_out          (flush_out),
    .stall_out          (stall_out),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .redirect_ready     (redirect_ready)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } csr_vec_t;

  csr_vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_csr(input string name, input logic [11:0] addr, input logic [63:0] exp);
    csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
    csr_addr  = addr;
    csr_wdata = data;
    csr_we    = 1'b1;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic raise(input logic exc, input logic mret, input logic [63:0] pc, input logic [3:0] cause);
    exception_in       = exc;
    mret_in            = mret;
    exception_pc_in    = pc;
    exception_cause_in = cause;
    tick();
    exception_in       = 1'b0;
    mret_in            = 1'b0;
  endtask

  initial begin
    vecs[0] = '{12'h305, 64'h4003,                64'h4000};
    vecs[1] = '{12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h88};
    vecs[2] = '{12'h340, 64'hDEAD_BEEF_1234_5678, 64'hDEAD_BEEF_1234_5678};
    vecs[3] = '{12'h341, 64'h1237,                64'h1234};
    vecs[4] = '{12'h342, 64'h8000_0000_0000_0005, 64'h8000_0000_0000_0005};
    vecs[5] = '{12'h7C0, 64'hFFFF,                64'h0};
    vecs[6] = '{12'h300, 64'h0,                   64'h0};

    reset = 1'b1; exception_in = 1'b0; exception_pc_in = '0; exception_cause_in = '0;
    mret_in = 1'b0; csr_addr = '0; csr_we = 1'b0; csr_wdata = '0; redirect_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_flush", {63'd0, flush_out}, 64'd0);
    check("rst_stall", {63'd0, stall_out}, 64'd0);
    check("rst_valid", {63'd0, redirect_valid}, 64'd0);
    check("rst_pc", redirect_pc, 64'd0);
    check_csr("rst_mtvec", 12'h305, 64'h8000_0000);
    check_csr("rst_mepc", 12'h341, 64'd0);
    tick();
    check_csr("rst_mcause", 12'h342, 64'd0);
    check_csr("rst_mscratch", 12'h340, 64'd0);
    check_csr("rst_mstatus", 12'h300, 64'd0);

    // CSR port table
    for (int i = 0; i < 7; i++) begin
      csr_write(vecs[i].addr, vecs[i].wdata);
      check_csr($sformatf("csr_%0h_v%0d", vecs[i].addr, i), vecs[i].addr, vecs[i].exp);
    end

    // Trap entry
    csr_write(12'h305, 64'h100);
    csr_write(12'h300, 64'h8);
    redirect_ready = 1'b1;
    raise(1'b1, 1'b0, 64'h1006, 4'd2);
    check("te_flush", {63'd0, flush_out}, 64'd1);
    check("te_stall_f", {63'd0, stall_out}, 64'd1);
    check("te_valid_f", {63'd0, redirect_valid}, 64'd0);
    check_csr("te_mepc", 12'h341, 64'h1004);
    check_csr("te_mcause", 12'h342, 64'd2);
    check_csr("te_mstatus", 12'h300, 64'h80);
    tick();
    check("te_flush_r", {63'd0, flush_out}, 64'd0);
    check("te_valid_r", {63'd0, redirect_valid}, 64'd1);
    check("te_pc", redirect_pc, 64'h100);
    check("te_stall_r", {63'd0, stall_out}, 64'd1);
    tick();
    check("te_valid_idle", {63'd0, redirect_valid}, 64'd0);
    check("te_stall_idle", {63'd0, stall_out}, 64'd0);

    // Backpressure with ignored events
    redirect_ready = 1'b0;
    raise(1'b1, 1'b0, 64'h5000, 4'd4);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), {63'd0, redirect_valid}, 64'd1);
      check($sformatf("bp_pc_%0d", i), redirect_pc, 64'h100);
      if (i == 1) raise(1'b1, 1'b1, 64'h9990, 4'd7);
      else tick();
    end
    check_csr("bp_mepc", 12'h341, 64'h5000);
    check_csr("bp_mcause", 12'h342, 64'd4);
    check_csr("bp_mstatus", 12'h300, 64'h0);
    redirect_ready = 1'b1;
    tick();
    check("bp_valid_done", {63'd0, redirect_valid}, 64'd0);

    // Return
    csr_write(12'h341, 64'h2000);
    csr_write(12'h300, 64'h80);
    raise(1'b0, 1'b1, 64'h0, 4'd0);
    check("ret_flush", {63'd0, flush_out}, 64'd1);
    check_csr("ret_mstatus", 12'h300, 64'h88);
    tick();
    check("ret_valid", {63'd0, redirect_valid}, 64'd1);
    check("ret_pc", redirect_pc, 64'h2000);
    tick();

    // Simultaneous exception and mret: exception wins
    raise(1'b1, 1'b1, 64'h3000, 4'd11);
    check_csr("sim_mcause", 12'h342, 64'd11);
    check_csr("sim_mepc", 12'h341, 64'h3000);
    check_csr("sim_mstatus", 12'h300, 64'h80);
    tick();
    check("sim_pc", redirect_pc, 64'h100);
    tick();

    // mepc software write collides with trap capture
    csr_addr = 12'h341; csr_wdata = 64'h7770; csr_we = 1'b1;
    raise(1'b1, 1'b0, 64'h6008, 4'd1);
    csr_we = 1'b0;
    check_csr("col_mepc", 12'h341, 64'h6008);
    tick(); tick();

    // mtvec software write in trap cycle does not change target
    csr_addr = 12'h305; csr_wdata = 64'h800; csr_we = 1'b1;
    raise(1'b1, 1'b0, 64'h7000, 4'd3);
    csr_we = 1'b0;
    check_csr("col_mtvec", 12'h305, 64'h800);
    tick();
    check("col_target", redirect_pc, 64'h100);
    tick();

    // Reset during REDIRECT
    redirect_ready = 1'b0;
    raise(1'b1, 1'b0, 64'h8000, 4'd5);
    tick();
    check("mr_valid_pre", {63'd0, redirect_valid}, 64'd1);
    reset = 1'b1;
    tick();
    check("mr_valid", {63'd0, redirect_valid}, 64'd0);
    check("mr_flush", {63'd0, flush_out}, 64'd0);
    check("mr_stall", {63'd0, stall_out}, 64'd0);
    tick();
    reset = 1'b0;
    check_csr("mr_mtvec", 12'h305, 64'h8000_0000);
    check_csr("mr_mepc", 12'h341, 64'd0);
    check_csr("mr_mcause", 12'h342, 64'd0);
    tick();
    check_csr("mr_mscratch", 12'h340, 64'd0);
    check_csr("mr_mstatus", 12'h300, 64'd0);
    check("mr_pc", redirect_pc, 64'd0);
    tick();
    check("mr_valid_post", {63'd0, redirect_valid}, 64'd0);
    check("mr_flush_post", {63'd0, flush_out}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
